// File: rtl/xk_update_sequencer.sv
// xk_update_sequencer
// Collects serial x_k elements into one W*N-bit assembly register. Each
// completed vector gets a one-cycle write strobe toward the x_k-previous
// store. A run repeats this for max_iter vectors and then pulses done.

module xk_update_sequencer #(
  parameter int number_of_equations_per_cluster = 9,
  parameter int element_width                   = 32,
  parameter int iter_width                      = 16
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                start,
  input  logic                                                abort,
  input  logic [iter_width-1:0]                               max_iter,
  input  logic                                                elem_valid,
  input  logic [element_width-1:0]                            elem_data,
  output logic                                                elem_ready,
  output logic                                                prev_write_enable,
  output logic [element_width*number_of_equations_per_cluster-1:0] prev_input_data,
  output logic                                                busy,
  output logic [iter_width-1:0]                               iteration_count,
  output logic                                                done
);

  localparam int N           = number_of_equations_per_cluster;
  localparam int W           = element_width;
  localparam int index_width = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [index_width-1:0] elem_index;
  logic [N*W-1:0]         assembly;
  logic [iter_width-1:0]  max_latched;
  logic                   accept;
  logic                   last_elem;
  logic                   launch;
  logic [iter_width-1:0]  count_inc;

  // An abort in COLLECT wins over a simultaneous element, so a cancelled
  // vector never picks up one more slot.
  assign accept    = (state == COLLECT) && elem_valid && !abort;
  assign last_elem = (elem_index == index_width'(N - 1));
  assign launch    = (state == IDLE) && start;
  assign count_inc = iteration_count + iter_width'(1);

  // The assembly register is the vector store's data bus. Slots that have
  // not been written keep their previous contents.
  assign prev_input_data = assembly;

  // Next-state decision for the run sequencing
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (max_iter == '0) ? DONE : COLLECT;
        end else begin
          state_next = IDLE;
        end
      end
      COLLECT: begin
        if (abort) begin
          state_next = IDLE;
        end else if (accept && last_elem) begin
          state_next = COMMIT;
        end else begin
          state_next = COLLECT;
        end
      end
      COMMIT: begin
        if (abort) begin
          state_next = IDLE;
        end else if (count_inc == max_latched) begin
          state_next = DONE;
        end else begin
          state_next = COLLECT;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and control outputs. The outputs are registered from the
  // next state, so they line up with the state and reset drops them at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      elem_ready        <= 1'b0;
      prev_write_enable <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      state             <= state_next;
      elem_ready        <= (state_next == COLLECT);
      prev_write_enable <= (state_next == COMMIT);
      busy              <= (state_next == COLLECT) || (state_next == COMMIT);
      done              <= (state_next == DONE);
    end
  end

  // Run bookkeeping: latch the limit at launch, count committed vectors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iteration_count <= '0;
      max_latched     <= '0;
    end else if (launch) begin
      iteration_count <= '0;
      max_latched     <= max_iter;
    end else if ((state == COMMIT) && !abort) begin
      iteration_count <= count_inc;
    end else begin
      iteration_count <= iteration_count;
    end
  end

  // Element assembly: write the accepted element into its slot, then advance the index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem_index <= '0;
      assembly   <= '0;
    end else if (launch) begin
      elem_index <= '0;
    end else if (accept) begin
      for (int i = 0; i < N; i++) begin
        if (elem_index == index_width'(i)) begin
          assembly[i*W +: W] <= elem_data;
        end
      end
      elem_index <= last_elem ? '0 : elem_index + index_width'(1);
    end else begin
      elem_index <= elem_index;
    end
  end

endmodule

// File: tb/tb_xk_update_sequencer.sv
// Testbench for xk_update_sequencer: cycle table, directed corner-case
// sequences, and randomized runs checked against a transaction-level model.

module tb_xk_update_sequencer;

  localparam int N  = 9;
  localparam int W  = 32;
  localparam int IW = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [IW-1:0]  max_iter = '0;
  logic           elem_valid = 1'b0;
  logic [W-1:0]   elem_data = '0;
  logic           elem_ready;
  logic           prev_write_enable;
  logic [N*W-1:0] prev_input_data;
  logic           busy;
  logic [IW-1:0]  iteration_count;
  logic           done;

  int tests = 0;
  int fails = 0;

  // Expected contents of the assembly register.
  logic [N*W-1:0] exp_vec = '0;

  typedef struct {
    logic          st;
    logic          ab;
    logic [IW-1:0] mi;
    logic          rdy;
    logic          we;
    logic          bsy;
    logic          dn;
    logic [IW-1:0] cnt;
  } vec_t;

  always #5 clk = ~clk;

  xk_update_sequencer #(
    .number_of_equations_per_cluster(N),
    .element_width(W),
    .iter_width(IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .max_iter(max_iter),
    .elem_valid(elem_valid),
    .elem_data(elem_data),
    .elem_ready(elem_ready),
    .prev_write_enable(prev_write_enable),
    .prev_input_data(prev_input_data),
    .busy(busy),
    .iteration_count(iteration_count),
    .done(done)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic rdy, input logic we, input logic bsy,
                         input logic dn, input logic [IW-1:0] cnt);
    chk_bit({tag, ".elem_ready"}, elem_ready, rdy);
    chk_bit({tag, ".prev_write_enable"}, prev_write_enable, we);
    chk_bit({tag, ".busy"}, busy, bsy);
    chk_bit({tag, ".done"}, done, dn);
    chk_cnt({tag, ".iteration_count"}, iteration_count, cnt);
  endtask

  function automatic vec_t mk(input logic st, input logic ab, input int mi, input logic rdy,
                              input logic we, input logic bsy, input logic dn, input int cnt);
    vec_t v;
    v.st  = st;
    v.ab  = ab;
    v.mi  = IW'(mi);
    v.rdy = rdy;
    v.we  = we;
    v.bsy = bsy;
    v.dn  = dn;
    v.cnt = IW'(cnt);
    return v;
  endfunction

  // One run from IDLE, checked by a transaction model. Every N accepted
  // elements form a vector, and the cycle after that vector completes must
  // show a write. After max writes, one done cycle follows and then idle.
  // abort_at: abort once this many elements are accepted (-1 = never).
  task automatic run(input int max, input int pct, input int abort_at, input bit noise,
                     output int writes, output bit aborted);
    int phase;
    int idx;
    int commits;
    int accepted;
    bit v;
    bit ab;
    bit finished;
    logic [W-1:0] d;
    phase = 0; idx = 0; commits = 0; accepted = 0;
    writes = 0; aborted = 1'b0; finished = 1'b0;
    start = 1'b1; max_iter = IW'(max);
    tick();
    start = 1'b0;
    chk_ctl("run.enter", 1'b1, 1'b0, 1'b1, 1'b0, '0);
    chk_vec("run.hold", prev_input_data, exp_vec);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      ab = (phase == 0) && (accepted == abort_at);
      v  = !ab && ($urandom_range(99) < pct);
      d  = $urandom;
      elem_valid = v; elem_data = d; abort = ab;
      if (noise) begin
        start    = 1'($urandom_range(1));
        max_iter = IW'($urandom_range(7));
      end
      tick();
      elem_valid = 1'b0; abort = 1'b0; start = 1'b0;
      if (prev_write_enable === 1'b1) writes++;
      if (ab) begin
        chk_ctl("run.abort", 1'b0, 1'b0, 1'b0, 1'b0, IW'(commits));
        aborted = 1'b1; finished = 1'b1;
        break;
      end
      case (phase)
        0: if (v) begin
             exp_vec[idx*W +: W] = d;
             idx++; accepted++;
             if (idx == N) begin idx = 0; phase = 1; end
           end
        1: begin commits++; phase = (commits == max) ? 2 : 0; end
        2: phase = 3;
        default: ;
      endcase
      case (phase)
        0: begin
             chk_ctl("run.collect", 1'b1, 1'b0, 1'b1, 1'b0, IW'(commits));
             chk_vec("run.collect.data", prev_input_data, exp_vec);
           end
        1: begin
             chk_ctl("run.commit", 1'b0, 1'b1, 1'b1, 1'b0, IW'(commits));
             chk_vec("run.commit.data", prev_input_data, exp_vec);
           end
        2: chk_ctl("run.done", 1'b0, 1'b0, 1'b0, 1'b1, IW'(max));
        default: begin
             chk_ctl("run.idle", 1'b0, 1'b0, 1'b0, 1'b0, IW'(max));
             finished = 1'b1;
           end
      endcase
      if (finished) break;
    end
    if (!finished) begin
      tests++; fails++;
      $display("FAIL run.timeout: got no completion within 4000 cycles expected completion");
    end
  endtask

  initial begin
    vec_t tbl[7];
    int   w;
    bit   a;
    int   m;

    // Each row: inputs for one cycle, then the outputs expected after the edge.
    tbl[0] = mk(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0); // idle stays idle
    tbl[1] = mk(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0); // max_iter=0 -> done
    tbl[2] = mk(1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0, 0); // start in DONE ignored
    tbl[3] = mk(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    tbl[4] = mk(1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b1, 1'b0, 0); // start beats abort in IDLE
    tbl[5] = mk(1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0); // abort in COLLECT
    tbl[6] = mk(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk_vec("reset.data", prev_input_data, '0);
    rst = 1'b0;
    tick();
    chk_ctl("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Cycle table
    for (int i = 0; i < 7; i++) begin
      start = tbl[i].st; abort = tbl[i].ab; max_iter = tbl[i].mi;
      tick();
      chk_ctl($sformatf("row%0d", i), tbl[i].rdy, tbl[i].we, tbl[i].bsy, tbl[i].dn, tbl[i].cnt);
    end
    start = 1'b0; abort = 1'b0;

    // max_iter=1 with elements 1..9 back to back
    start = 1'b1; max_iter = 16'd1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= N; i++) begin
      elem_valid = 1'b1; elem_data = W'(i);
      exp_vec[(i-1)*W +: W] = W'(i);
      tick();
      chk_bit($sformatf("seq1.we%0d", i), prev_write_enable, (i == N));
    end
    elem_valid = 1'b0;
    chk_vec("seq1.data", prev_input_data, exp_vec);
    tick();
    chk_ctl("seq1.done", 1'b0, 1'b0, 1'b0, 1'b1, 16'd1);
    tick();
    chk_ctl("seq1.idle", 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);

    // max_iter=3 with 50% valid
    run(3, 50, -1, 1'b0, w, a);
    chk_cnt("req036.writes", IW'(w), 16'd3);

    // Abort after 5 elements of iteration 2, then restart
    run(4, 100, N + 5, 1'b0, w, a);
    chk_bit("req038.aborted", a, 1'b1);
    chk_cnt("req038.writes", IW'(w), 16'd1);
    run(4, 70, -1, 1'b0, w, a);
    chk_cnt("req038.restart_writes", IW'(w), 16'd4);

    // start/max_iter noise while busy and in DONE
    run(3, 60, -1, 1'b1, w, a);
    chk_cnt("req040.writes", IW'(w), 16'd3);

    // Randomized runs
    for (int k = 0; k < 4; k++) begin
      m = $urandom_range(4, 1);
      run(m, $urandom_range(100, 30), -1, 1'b1, w, a);
      chk_cnt($sformatf("rand%0d.writes", k), IW'(w), IW'(m));
    end

    // Reset asserted during COMMIT
    start = 1'b1; max_iter = 16'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      elem_valid = 1'b1; elem_data = $urandom;
      tick();
    end
    elem_valid = 1'b0;
    chk_bit("req039.in_commit", prev_write_enable, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_ctl("req039.async", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk_vec("req039.async.data", prev_input_data, '0);
    tick();
    chk_ctl("req039.held", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    rst = 1'b0;
    exp_vec = '0;
    run(1, 100, -1, 1'b0, w, a);
    chk_cnt("req039.recover_writes", IW'(w), 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/xk_update_sequencer.md
XK_UPDATE_SEQUENCER -- requirements
Module: xk_update_sequencer

Interface
REQ-001 Parameter number_of_equations_per_cluster, default 9, elements per x_k vector (N); SHALL be >= 2.
REQ-002 Parameter element_width, default 32, bits per element (W).
REQ-003 Parameter iter_width, default 16, width of iteration limit and counter.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  launches a run; sampled only in IDLE.
REQ-007 abort  input  1  cancels a run; sampled in every state except IDLE.
REQ-008 max_iter  input  iter_width  number of vectors to commit; latched on accepted start.
REQ-009 elem_valid  input  1  serial element present on elem_data.
REQ-010 elem_data  input  W  serial element from the update datapath, element 0 first.
REQ-011 elem_ready  output  1  sequencer accepts an element this cycle.
REQ-012 prev_write_enable  output  1  write strobe to the x_k-previous vector store.
REQ-013 prev_input_data  output  W*N  assembled vector; element i SHALL occupy bits [W*i+W-1 : W*i].
REQ-014 busy  output  1  high in COLLECT and COMMIT.
REQ-015 iteration_count  output  iter_width  vectors committed in the current or last run.
REQ-016 done  output  1  single-cycle pulse at the end of a completed run.

Function
REQ-017 States SHALL be IDLE, COLLECT, COMMIT, DONE, held in a registered state machine.
REQ-018 IDLE with start=1 and max_iter!=0: latch max_iter, clear iteration_count and element index, go to COLLECT.
REQ-019 IDLE with start=1 and max_iter==0: go to DONE with iteration_count cleared and no write.
REQ-020 elem_ready SHALL be 1 only in COLLECT; an element is accepted when elem_valid and elem_ready are both 1.
REQ-021 Each accepted element SHALL be stored into slot (element index) of the assembly register, and the index SHALL increment by 1.
REQ-022 Acceptance of element N-1 SHALL move the state to COMMIT on the same edge; the index SHALL wrap to 0.
REQ-023 Gaps in elem_valid SHALL stall COLLECT without changing the index or stored slots.
REQ-024 COMMIT SHALL last exactly one cycle with prev_write_enable=1; prev_write_enable SHALL be 0 in all other states.
REQ-025 prev_input_data SHALL be driven directly from the assembly register at all times; unwritten slots keep their previous values.
REQ-026 On leaving COMMIT, iteration_count SHALL increment by 1; if the new value equals latched max_iter, go to DONE, else go to COLLECT.
REQ-027 Latency: element N-1 accepted at edge t -> prev_write_enable high during cycle after t -> done high during following cycle on the final iteration.
REQ-028 DONE SHALL assert done for exactly one cycle, then return to IDLE; start during DONE SHALL be ignored.
REQ-029 abort=1 in COLLECT or COMMIT SHALL return to IDLE on the next edge with no done pulse and no write in that cycle; iteration_count SHALL hold its value.
REQ-030 abort and start both high in IDLE: start SHALL take effect; abort SHALL be ignored.
REQ-031 start and max_iter SHALL be ignored while busy; changes to max_iter mid-run SHALL not affect the run.

Reset
REQ-032 rst=1 SHALL immediately force state IDLE, element index 0, assembly register 0, iteration_count 0, latched max_iter 0.
REQ-033 During and after reset, elem_ready, prev_write_enable, busy and done SHALL be 0, and prev_input_data SHALL be all zeros.
REQ-034 Reset asserted mid-COLLECT or during COMMIT SHALL discard the partial vector and suppress the write strobe in that cycle.

Verification
REQ-035 max_iter=1, elements 1..9 on consecutive cycles -> one prev_write_enable pulse, prev_input_data = {9,8,...,1} (element 0 = 1 in bits [31:0]), done pulse, iteration_count=1.
REQ-036 max_iter=3, elem_valid toggled 50% -> exactly 3 write pulses, one per 9 accepted elements, done after the third, busy low afterwards.
REQ-037 start with max_iter=0 -> done pulse on the next cycle, no write pulse, iteration_count=0.
REQ-038 abort after 5 accepted elements of iteration 2 with max_iter=4 -> IDLE next edge, no write, no done, iteration_count=1; restart then commits a fresh full vector.
REQ-039 rst asserted during COMMIT -> prev_write_enable low immediately, all outputs zero, state IDLE.
REQ-040 start pulsed during COLLECT and DONE with max_iter changed -> no effect on the run, and the original count is completed.
